// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : UART receive stage. Oversamples an asynchronous 8N1 line
//                (8E1 when UART_RX_PARITY_EN is defined) at CLKS_PER_BIT
//                clocks per bit. Each received byte is presented through a
//                held valid/ack handshake. Framing, parity and overrun
//                errors are flagged as one-cycle pulses.
//  Macro       : UART_RX_PARITY_EN - adds the even-parity bit and parity_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       framing_err,
   output logic       parity_err,
   output logic       overrun
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

   // Reject unusable bit periods at elaboration time.
   if ((CLKS_PER_BIT < 4) || ((CLKS_PER_BIT % 2) != 0)) begin : g_bad_clks_per_bit
      $error("uart_receiver: CLKS_PER_BIT must be even and at least 4");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   // Synchronizer and edge-detect history
   logic             sync1_q, sync2_q, rx_prev_q;
   logic             rx_s;

   // Frame FSM
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;

   // Stop-sample verdict, consumed by the output stage one cycle later
   logic             good_q, good_d;
   logic             fe_pend_q, fe_pend_d;

   // Registered outputs
   logic [7:0]       data_q, data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             framing_err_q, framing_err_d;
   logic             overrun_q, overrun_d;
   logic             load;

`ifdef UART_RX_PARITY_EN
   logic             par_bad_q, par_bad_d;
   logic             pe_pend_q, pe_pend_d;
   logic             parity_err_q, parity_err_d;
`endif

   assign rx_s = sync2_q;

   // Two-flop synchronizer on the asynchronous line plus one flop of history
   // so IDLE only reacts to a genuine 1->0 transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync1_q   <= rx;
         sync2_q   <= sync1_q;
         rx_prev_q <= sync2_q;
      end
   end

   // Frame sequencing: next-state, counter, bit index and shift register.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      good_d    = 1'b0;
      fe_pend_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      pe_pend_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            // After a framing error the line must go high again before the
            // next start edge can be seen, so a break flags only once.
            if (rx_prev_q && !rx_s) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
               par_bad_d = 1'b0;
`endif
               // A line already back high at mid-start is a glitch.
               state_d = rx_s ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d     = '0;
               // Even parity: data plus parity bit must XOR to zero.
               par_bad_d = ^{shift_q, rx_s};
               state_d   = S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               if (!rx_s) begin
                  fe_pend_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (par_bad_q) begin
                  pe_pend_d = 1'b1;
`endif
               end else begin
                  good_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output stage: a good frame loads unless a byte is still pending; an ack
   // in the same cycle as the load frees the slot, so the load wins.
   always_comb begin
      load          = good_q && (!rx_valid_q || rx_ack);
      data_d        = load ? shift_q : data_q;
      rx_valid_d    = load ? 1'b1 : (rx_valid_q && !rx_ack);
      overrun_d     = good_q && rx_valid_q && !rx_ack;
      framing_err_d = fe_pend_q;
`ifdef UART_RX_PARITY_EN
      parity_err_d  = pe_pend_q;
`endif
   end

   // All frame and output state; a mid-frame reset abandons the frame silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         idx_q         <= 3'd0;
         shift_q       <= 8'h00;
         good_q        <= 1'b0;
         fe_pend_q     <= 1'b0;
         data_q        <= 8'h00;
         rx_valid_q    <= 1'b0;
         framing_err_q <= 1'b0;
         overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q     <= 1'b0;
         pe_pend_q     <= 1'b0;
         parity_err_q  <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         shift_q       <= shift_d;
         good_q        <= good_d;
         fe_pend_q     <= fe_pend_d;
         data_q        <= data_d;
         rx_valid_q    <= rx_valid_d;
         framing_err_q <= framing_err_d;
         overrun_q     <= overrun_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q     <= par_bad_d;
         pe_pend_q     <= pe_pend_d;
         parity_err_q  <= parity_err_d;
`endif
      end
   end

   assign data        = data_q;
   assign rx_valid    = rx_valid_q;
   assign framing_err = framing_err_q;
   assign overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = parity_err_q;
`else
   assign parity_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

UART receive stage: the consumer of the serial line driven by the UART transmitter, and its counterpart on the receive side. It converts an asynchronous 8N1 serial stream (optionally 8E1) back into bytes. It oversamples the line at `CLKS_PER_BIT` clocks per bit and presents each received byte through a held valid/ack handshake. It flags framing, parity and overrun errors.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit. Must be even and at least 4.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx` input 1: serial line, asynchronous to `clk`; idle high.
- `data` output 8: last accepted byte, LSB received first.
- `rx_valid` output 1: `data` holds an unconsumed byte.
- `rx_ack` input 1: consumer takes `data`; honoured only while `rx_valid`=1.
- `framing_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `parity_err` output 1: one-cycle pulse when parity mismatches. Constant 0 without the parity feature.
- `overrun` output 1: one-cycle pulse when a good frame completes while `rx_valid`=1.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1.
- The bit counter is `$clog2(CLKS_PER_BIT)` wide. The bit index is 3 bits.
- **IDLE**
  - A falling edge on `rx_s` (previous 1, current 0) moves to START and clears the counter.
- **START**
  - Count to `CLKS_PER_BIT/2-1`, then sample `rx_s`.
  - If it is 0, go to DATA with counter and index cleared.
  - If it is 1, treat it as a glitch and return to IDLE with no flags.
- **DATA**
  - Each time the counter reaches `CLKS_PER_BIT-1`, sample `rx_s` into the shift register (LSB first) and clear the counter.
  - After bit index 7, go to PARITY if the feature is enabled, otherwise to STOP.
- **PARITY** (feature only)
  - After `CLKS_PER_BIT` cycles, sample the parity bit and compute even parity over the 8 data bits plus the parity bit.
  - Record a mismatch internally, then go to STOP.
- **STOP**
  - After `CLKS_PER_BIT` cycles, sample `rx_s`.
  - Sample 0: pulse `framing_err`, discard the byte, go to IDLE.
  - Sample 1 with a parity mismatch: pulse `parity_err`, discard the byte, go to IDLE.
  - Sample 1 and parity good, with `rx_valid`=0: load `data`, set `rx_valid`, go to IDLE.
  - Sample 1 and parity good, with `rx_valid`=1: pulse `overrun`, leave `data` unchanged (the new byte is lost), go to IDLE.
- **Handshake**
  - `rx_ack`=1 while `rx_valid`=1 clears `rx_valid` on the next edge.
  - If `rx_ack` and a good-frame load fall in the same cycle, the load wins: `rx_valid` stays 1, `data` takes the new byte, and there is no `overrun`.
  - `rx_ack` while `rx_valid`=0 is ignored.
- After a framing error, IDLE needs `rx_s` to return high before it can detect the next falling edge. A line held low (break) therefore produces exactly one `framing_err`.

## Timing
- **Reset values:** `data`=0x00, `rx_valid`=0, `framing_err`=0, `parity_err`=0, `overrun`=0, state=IDLE, counter and index=0.
- **Reset mid-frame:** the frame is abandoned and nothing is flagged.
- **Cycle reference:** T is the rising edge at which the first synchronizer flop captures `rx`=0.
  - The start bit is sampled at T+1+`CLKS_PER_BIT/2`.
  - Data bit i is sampled `CLKS_PER_BIT*(i+1)` cycles after the start sample.
- **Latency without parity:** `rx_valid` (or an error pulse) is visible `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3` cycles after T. With the default of 16, that is 155 cycles.
- **Latency with parity:** add `CLKS_PER_BIT`.
- **Pulse width:** every error pulse lasts exactly one cycle.
- **Frame spacing:** back-to-back frames with no idle gap are received. The next start edge is detected immediately after the STOP sample.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - The frame is start, 8 data bits, even parity bit, stop (8E1).
  - The PARITY state exists and `parity_err` is driven.
- Undefined:
  - The frame is 8N1.
  - The PARITY state is not compiled and `parity_err` is tied to 0.

## Test plan
- **Single byte:** send 0xA5 as 8N1 with `CLKS_PER_BIT`=16 and `rx_ack` held 0. Require `data`=0xA5, `rx_valid` rising exactly 155 cycles after T and staying high until acked.
- **Back-to-back with ack:** send 0x00 then 0xFF with no gap, pulsing `rx_ack` once between them. Require both bytes delivered in order and no `overrun`.
- **Overrun:** send 0x3C then 0xC3 with no ack. Require `data`=0x3C, `rx_valid`=1, and `overrun` pulsing one cycle at the second frame's stop sample.
- **Framing error:** send 0x55 with the stop bit driven 0. Require one `framing_err` pulse, `rx_valid`=0 and `data` unchanged.
- **Glitch:** drive a low glitch of 4 cycles on the idle line. Require the state to return to IDLE with no outputs changing. Then assert `rst_n`=0 mid-way through a 0x81 frame and require all outputs at their reset values.
- **Parity** (`UART_RX_PARITY_EN` defined): send 0x07 with parity bit 1 and require `data`=0x07. Send 0x07 with parity bit 0 and require one `parity_err` pulse and `rx_valid` unchanged.
